// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg: FSM states and arithmetic helpers shared by the conv2d_stream files.
package conv_pkg;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Clamp a sign-extended accumulator to the signed range of a bits-wide word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] acc, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// conv_line_buffer: K-1 row delay lines feeding a KxK sliding window, advanced only on accepted pixels.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   accept,
  input  logic signed [BITS-1:0] pix,
  input  logic                   pos_valid,
  input  logic                   pos_last,
  output logic signed [BITS-1:0] window [KERNEL_SIZE*KERNEL_SIZE],
  output logic                   window_valid,
  output logic                   window_last
);

  localparam int K    = KERNEL_SIZE;
  localparam int TAPS = K * K;

  logic signed [BITS-1:0] line_mem [K-1][IMG_WIDTH];
  // tap[k] is the pixel in the current column, k rows above the incoming one.
  logic signed [BITS-1:0] tap [K];

  always_comb begin
    tap[0] = pix;
    for (int k = 1; k < K; k++) begin
      tap[k] = line_mem[k-1][IMG_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < K - 1; k++) begin
        for (int w = 0; w < IMG_WIDTH; w++) begin
          line_mem[k][w] <= '0;
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        window[t] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < K - 1; k++) begin
        line_mem[k][0] <= tap[k];
        for (int w = 1; w < IMG_WIDTH; w++) begin
          line_mem[k][w] <= line_mem[k][w-1];
        end
      end
      // Window row 0 is the oldest image row; column K-1 is the newest pixel.
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          window[i*K+j] <= window[i*K+j+1];
        end
        window[i*K+K-1] <= tap[K-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_valid <= 1'b0;
      window_last  <= 1'b0;
    end else begin
      window_valid <= accept & pos_valid;
      window_last  <= accept & pos_valid & pos_last;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// conv2d_stream: streaming KxK "valid" convolution with 2-cycle MAC pipeline and saturation.
// Optional macro CONV2D_RELU_EN clamps negative saturated results to zero.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [BITS-1:0] kernel_in,
  input  logic                   kernel_write_en,
  output logic                   kernel_ready,
  input  logic signed [BITS-1:0] pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic signed [BITS-1:0] pix_out,
  output logic                   out_valid,
  output logic                   frame_done
);

  localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_W  = (clog2(TAPS) < 1) ? 1 : clog2(TAPS);
  localparam int COL_W  = clog2(IMG_WIDTH);
  localparam int ROW_W  = clog2(IMG_HEIGHT);
  localparam int PROD_W = 2 * BITS;
  localparam int ACC_W  = PROD_W + clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_COEF = CNT_W'(TAPS - 1);

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       cnt;
  logic signed [BITS-1:0] coef [TAPS];
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   accept;
  logic                   pos_valid;
  logic                   pos_last;

  logic signed [BITS-1:0] window [TAPS];
  logic                   window_valid;
  logic                   window_last;

  logic signed [PROD_W-1:0] prod [TAPS];
  logic                     s1_valid;
  logic                     s1_last;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [63:0]       acc_wide;
  logic signed [BITS-1:0]   result;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    case (state)
      ST_LOAD: if (kernel_write_en && cnt == LAST_COEF) state_nx = ST_RUN;
      ST_RUN:  pix_ready = 1'b1;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      kernel_ready <= 1'b0;
    end else if (state == ST_LOAD && kernel_write_en) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_COEF) kernel_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD && kernel_write_en) coef[cnt] <= kernel_in;
  end

  assign accept    = pix_valid & pix_ready;
  assign pos_valid = (int'(row) >= KERNEL_SIZE - 1) && (int'(col) >= KERNEL_SIZE - 1);
  assign pos_last  = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  conv_line_buffer #(
    .BITS        (BITS),
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_WIDTH   (IMG_WIDTH)
  ) u_line_buffer (
    .clk          (clk),
    .reset        (reset),
    .accept       (accept),
    .pix          (pix_in),
    .pos_valid    (pos_valid),
    .pos_last     (pos_last),
    .window       (window),
    .window_valid (window_valid),
    .window_last  (window_last)
  );

  // Kernel index is mirrored against the window so the result is a true convolution.
  always_ff @(posedge clk) begin
    if (window_valid) begin
      for (int k = 0; k < TAPS; k++) begin
        prod[k] <= PROD_W'(window[k]) * PROD_W'(coef[TAPS-1-k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= window_valid;
      s1_last  <= window_last;
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_sum = acc_sum + ACC_W'(prod[k]);
    end
    acc_shift = acc_sum >>> OUT_SHIFT;
    acc_wide  = {{(64 - ACC_W){acc_shift[ACC_W-1]}}, acc_shift};
    result    = BITS'(sat(acc_wide, BITS));
`ifdef CONV2D_RELU_EN
    if (result[BITS-1]) result = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_out    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      frame_done <= s1_last;
      if (s1_valid) pix_out <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`default_nettype none
// tb_conv2d_stream: directed + randomized bench comparing conv2d_stream with a frame-level convolution model.
module tb_conv2d_stream;

  localparam int BITS      = 9;
  localparam int K         = 3;
  localparam int W         = 16;
  localparam int H         = 16;
  localparam int OUT_SHIFT = 0;
  localparam int TAPS      = K * K;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic signed [BITS-1:0] kernel_in = '0;
  logic                   kernel_write_en = 1'b0;
  logic                   kernel_ready;
  logic signed [BITS-1:0] pix_in = '0;
  logic                   pix_valid = 1'b0;
  logic                   pix_ready;
  logic signed [BITS-1:0] pix_out;
  logic                   out_valid;
  logic                   frame_done;

  conv2d_stream #(
    .BITS        (BITS),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .OUT_SHIFT   (OUT_SHIFT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .kernel_in       (kernel_in),
    .kernel_write_en (kernel_write_en),
    .kernel_ready    (kernel_ready),
    .pix_in          (pix_in),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_out         (pix_out),
    .out_valid       (out_valid),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit done;
    int cyc;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   ker [TAPS];
  int   img [H][W];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stray_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) obs_q.push_back('{int'(pix_out), frame_done, cyc});
    else if (frame_done) stray_done++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Convolution by definition: flipped kernel times the KxK image patch ending at (r,c).
  function automatic int ref_pix(input int r, input int c);
    longint acc;
    longint lim;
    acc = 0;
    lim = longint'(1) << (BITS - 1);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        acc += longint'(ker[(K-1-i)*K + (K-1-j)]) * longint'(img[r-K+1+i][c-K+1+j]);
      end
    end
    acc = acc >>> OUT_SHIFT;
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
`ifdef CONV2D_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return int'(acc);
  endfunction

  task automatic gen_img(input int mode, input int p);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       img[r][c] = r * W + c;
          1:       img[r][c] = p;
          2:       img[r][c] = int'($urandom_range(0, 40)) - 20;
          default: img[r][c] = int'($urandom_range(0, 511)) - 256;
        endcase
      end
    end
  endtask

  task automatic load_kernel(input int first, input int last);
    for (int n = first; n <= last; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        kernel_write_en = 1'b0;
      end
      @(negedge clk);
      kernel_write_en = 1'b1;
      kernel_in       = ker[n][BITS-1:0];
    end
    @(negedge clk);
    kernel_write_en = 1'b0;
  endtask

  // gap: 0 = always valid, 1 = 1,0,0,1 pattern, other = random.
  task automatic drive_frame(input int gap, input bit junk, input int max_acc);
    int r;
    int c;
    int acc_n;
    int phase;
    int budget;
    bit v;
    r = 0; c = 0; acc_n = 0; phase = 0; budget = W * H * 8;
    while (acc_n < max_acc && budget > 0) begin
      @(negedge clk);
      budget--;
      case (gap)
        0:       v = 1'b1;
        1:       v = (phase % 4 == 0) || (phase % 4 == 3);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      phase++;
      pix_valid       = v;
      pix_in          = img[r][c][BITS-1:0];
      kernel_write_en = junk;
      kernel_in       = BITS'(5);
      if (v && pix_ready) begin
        if (r >= K - 1 && c >= K - 1)
          exp_q.push_back('{ref_pix(r, c), (r == H - 1) && (c == W - 1), cyc + 3});
        acc_n++;
        if (c == W - 1) begin
          c = 0;
          r = (r == H - 1) ? 0 : r + 1;
        end else begin
          c++;
        end
      end
    end
    @(negedge clk);
    pix_valid       = 1'b0;
    kernel_write_en = 1'b0;
    check("accepted_pixels", acc_n, max_acc);
    if (max_acc == W * H) repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_value"}, obs_q[k].val, exp_q[k].val);
      check({tag, "_frame_done"}, obs_q[k].done, exp_q[k].done);
      check({tag, "_cycle"}, obs_q[k].cyc, exp_q[k].cyc);
    end
    check({tag, "_stray_done"}, stray_done, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_ends(input string tag, input int first, input int last);
    check({tag, "_nonempty"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0) begin
      check({tag, "_first"}, obs_q[0].val, first);
      check({tag, "_last"}, obs_q[obs_q.size()-1].val, last);
      check({tag, "_last_done"}, obs_q[obs_q.size()-1].done, 1);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset           = 1'b1;
    pix_valid       = 1'b0;
    kernel_write_en = 1'b0;
    @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_kernel_ready", kernel_ready, 0);
    check("rst_pix_ready", pix_ready, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("stale_outputs", obs_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("init_out_valid", out_valid, 0);
    check("init_frame_done", frame_done, 0);
    check("init_pix_out", pix_out, 0);
    check("init_kernel_ready", kernel_ready, 0);
    check("init_pix_ready", pix_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    // Identity kernel, ramp image, eight coefficients first.
    foreach (ker[i]) ker[i] = 0;
    ker[TAPS/2] = 1;
    load_kernel(0, TAPS - 2);
    @(negedge clk);
    check("partial_kernel_ready", kernel_ready, 0);
    check("partial_pix_ready", pix_ready, 0);
    load_kernel(TAPS - 1, TAPS - 1);
    check("full_kernel_ready", kernel_ready, 1);
    check("full_pix_ready", pix_ready, 1);
    gen_img(0, 0);
    drive_frame(0, 1'b0, W * H);
    check_ends("identity", 17, 238);
    check_frame("identity");

    // Writes of 5 during RUN must not disturb the loaded identity kernel.
    gen_img(3, 0);
    drive_frame(2, 1'b1, W * H);
    check_frame("junk_write");

    // All-ones kernel: saturation both ways, then gapped input.
    apply_reset();
    foreach (ker[i]) ker[i] = 1;
    load_kernel(0, TAPS - 1);
    gen_img(1, 100);
    drive_frame(0, 1'b0, W * H);
    check_frame("sat_pos");
    gen_img(1, -100);
    drive_frame(0, 1'b0, W * H);
    check_frame("sat_neg");
    gen_img(1, 10);
    drive_frame(1, 1'b0, W * H);
    check_frame("gapped");

    // Random kernel and random images.
    apply_reset();
    foreach (ker[i]) ker[i] = int'($urandom_range(0, 6)) - 3;
    load_kernel(0, TAPS - 1);
    gen_img(2, 0);
    drive_frame(2, 1'b0, W * H);
    check_frame("rand_small");
    gen_img(3, 0);
    drive_frame(0, 1'b0, W * H);
    check_frame("rand_full");

    // Abort a frame after 40 pixels, then reload with a negated identity.
    gen_img(0, 0);
    drive_frame(0, 1'b0, 40);
    apply_reset();
    foreach (ker[i]) ker[i] = 0;
    ker[TAPS/2] = -1;
    load_kernel(0, TAPS - 1);
    drive_frame(0, 1'b0, W * H);
`ifdef CONV2D_RELU_EN
    check_ends("neg_identity", 0, 0);
`else
    check_ends("neg_identity", -17, -238);
`endif
    check_frame("neg_identity");

    check("stray_frame_done", stray_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
